// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared FSM encodings and counter sizing for the SR pulse driver
//
// Purpose: state encodings for the pulse FSM and the debounce counter width helper.
// Ports:   none (package).
package sr_drv_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SET_P = 2'd1;
  localparam logic [1:0] RST_P = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  // Width needed to hold the values 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchroniser, debouncer and rising-edge event for one button
//
// Purpose: brings a raw, bouncy button into the clk domain, filters it and emits a
//          one-cycle registered event on each rising edge of the debounced level.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   raw      in   raw button input, asynchronous to clk
//   rise_ev  out  one-cycle pulse after the debounced level goes 0->1
module debounce_channel
  import sr_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise_ev
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      rise_ev <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // Registered edge detect keeps the event free of any combinational path.
      rise_ev <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_pulse_driver.sv
// rtl/sr_pulse_driver.sv - debounced set/reset buttons to exclusive fixed-length s/r pulses
//
// Purpose: drives an SR latch from two raw buttons, never asserting s and r together,
//          and tracks the state the latch should hold.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   set_raw   in   raw set button
//   rst_raw   in   raw reset button
//   s         out  set pulse, PULSE_LEN cycles
//   r         out  reset pulse, PULSE_LEN cycles
//   q_track   out  expected latch state
//   conflict  out  one-cycle flag when both debounced edges coincide
//   busy      out  high whenever the FSM is not idle
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_LEN       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic rst_raw,
  output logic s,
  output logic r,
  output logic q_track,
  output logic conflict,
  output logic busy
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic          set_ev;
  logic          rst_ev;
  logic [1:0]    state;
  logic [PW-1:0] plen;
  logic          pending;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (set_raw),
    .rise_ev (set_ev)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (rst_raw),
    .rise_ev (rst_ev)
  );

  logic both_ev;
  logic set_only;
  logic rst_only;
  logic opp_only;

  assign both_ev  = set_ev & rst_ev;
  assign set_only = set_ev & ~rst_ev;
  assign rst_only = rst_ev & ~set_ev;
  // While busy, q_track already reflects the active or just-finished pulse,
  // so the opposite kind is always the one that would flip it.
  assign opp_only = q_track ? rst_only : set_only;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      plen     <= '0;
      pending  <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      q_track  <= 1'b0;
      conflict <= 1'b0;
      busy     <= 1'b0;
    end else begin
      conflict <= both_ev;
      case (state)
        IDLE: begin
          if (set_only) begin
            state   <= SET_P;
            s       <= 1'b1;
            q_track <= 1'b1;
            busy    <= 1'b1;
            plen    <= '0;
          end else if (rst_only) begin
            state   <= RST_P;
            r       <= 1'b1;
            q_track <= 1'b0;
            busy    <= 1'b1;
            plen    <= '0;
          end
        end

        SET_P, RST_P: begin
          if (opp_only) pending <= 1'b1;
          if (plen == PW'(PULSE_LEN - 1)) begin
            state <= GAP;
            s     <= 1'b0;
            r     <= 1'b0;
            plen  <= '0;
          end else begin
            plen <= plen + PW'(1);
          end
        end

        GAP: begin
          // An opposite event landing in the gap is issued directly as well.
          if (pending || opp_only) begin
            pending <= 1'b0;
            plen    <= '0;
            if (q_track) begin
              state   <= RST_P;
              r       <= 1'b1;
              q_track <= 1'b0;
            end else begin
              state   <= SET_P;
              s       <= 1'b1;
              q_track <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          s     <= 1'b0;
          r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb/tb_sr_pulse_driver.sv - scoreboard bench for sr_pulse_driver against a behavioural model
module tb_sr_pulse_driver;

  localparam int DC = 4;
  localparam int PL = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic set_raw;
  logic rst_raw;
  logic s, r, q_track, conflict, busy;

  always #5 clk = ~clk;

  sr_pulse_driver #(.DEBOUNCE_CYCLES(DC), .PULSE_LEN(PL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_raw  (set_raw),
    .rst_raw  (rst_raw),
    .s        (s),
    .r        (r),
    .q_track  (q_track),
    .conflict (conflict),
    .busy     (busy)
  );

  typedef struct packed {
    logic s;
    logic r;
    logic q;
    logic c;
    logic b;
  } obs_t;

  obs_t exp_q[$];
  int   ncmp = 0;
  int   nerr = 0;
  bit   stop_mon = 0;

  // Behavioural model: per channel a two-sample delay line, a run length of
  // consecutive samples disagreeing with the filtered level, and a two-stage
  // delivery of rise events; the driver is "idle / pulsing with N left / gap".
  int sy1[2], sy2[2], lvl[2], run[2], rose[2], evq[2];
  int mode, kind, left, pend;
  int mq, ms, mr, mc, mb;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sy1[i] = 0; sy2[i] = 0; lvl[i] = 0; run[i] = 0; rose[i] = 0; evq[i] = 0;
    end
    mode = 0; kind = 0; left = 0; pend = 0;
    mq = 0; ms = 0; mr = 0; mc = 0; mb = 0;
  endtask

  task automatic start_pulse(input int k);
    mode = 1; kind = k; left = PL - 1; mq = k;
  endtask

  task automatic model_step(input int rn, input int raw_s, input int raw_r);
    int es, er, both, opp, flipped;
    int raw[2];
    if (rn == 0) begin
      model_reset();
      return;
    end
    es = evq[0]; er = evq[1];
    both = es & er;
    mc = both;
    opp = (!both) && (mq != 0 ? er != 0 : es != 0);
    case (mode)
      0: begin
        if (!both && es != 0) start_pulse(1);
        else if (!both && er != 0) start_pulse(0);
      end
      1: begin
        if (opp) pend = 1;
        if (left > 0) left--;
        else mode = 2;
      end
      default: begin
        if (pend != 0 || opp) begin
          pend = 0;
          start_pulse(mq != 0 ? 0 : 1);
        end else begin
          mode = 0;
        end
      end
    endcase
    ms = (mode == 1 && kind == 1) ? 1 : 0;
    mr = (mode == 1 && kind == 0) ? 1 : 0;
    mb = (mode != 0) ? 1 : 0;
    raw[0] = raw_s; raw[1] = raw_r;
    for (int i = 0; i < 2; i++) begin
      evq[i] = rose[i];
      flipped = 0;
      if (sy2[i] == lvl[i]) begin
        run[i] = 0;
      end else begin
        run[i]++;
        if (run[i] == DC) begin
          lvl[i] = 1 - lvl[i];
          run[i] = 0;
          flipped = 1;
        end
      end
      rose[i] = (flipped != 0 && lvl[i] == 1) ? 1 : 0;
      sy2[i] = sy1[i];
      sy1[i] = raw[i];
    end
  endtask

  // One clock of stimulus: drive away from the edge and queue the expected
  // outputs for the rising edge that follows.
  task automatic cycle(input logic rn, input logic sr, input logic rr);
    obs_t e;
    @(negedge clk);
    rst_n   = rn;
    set_raw = sr;
    rst_raw = rr;
    model_step(int'(rn), int'(sr), int'(rr));
    e.s = ms[0]; e.r = mr[0]; e.q = mq[0]; e.c = mc[0]; e.b = mb[0];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    ncmp++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic at_edge_chk(input string name, input logic got_sel, input logic want);
    @(posedge clk);
    #2;
    chk(name, {7'd0, got_sel ? s : conflict}, {7'd0, want});
  endtask

  initial begin
    obs_t e, got;
    rst_n = 1'b0; set_raw = 1'b0; rst_raw = 1'b0;
    model_reset();

    fork
      forever begin
        @(posedge clk);
        #1;
        if (!stop_mon && exp_q.size() > 0) begin
          e   = exp_q.pop_front();
          got = '{s, r, q_track, conflict, busy};
          ncmp++;
          if (got !== e) begin
            nerr++;
            $display("FAIL scoreboard at %0t: got s,r,q,c,b=%b want %b", $time, got, e);
          end
          ncmp++;
          if (s && r) begin
            nerr++;
            $display("FAIL s_and_r at %0t: got s=%b r=%b want not both", $time, s, r);
          end
        end
      end
    join_none

    #12;
    chk("reset_outputs", {3'd0, s, r, q_track, conflict, busy}, 8'd0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // 1: set held high; edge k is the k-th edge sampling it (starting at 0).
    for (int k = 0; k <= 12; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (k == 6)  at_edge_chk("t1_s_edge6", 1'b1, 1'b0);
      if (k == 7)  at_edge_chk("t1_s_edge7", 1'b1, 1'b1);
      if (k == 9)  at_edge_chk("t1_s_edge9", 1'b1, 1'b1);
      if (k == 10) at_edge_chk("t1_s_edge10", 1'b1, 1'b0);
    end
    #1 chk("t1_q_track", {7'd0, q_track}, 8'd1);
    repeat (12) cycle(1'b1, 1'b0, 1'b0);

    // 2: bounce then settle high.
    for (int k = 0; k < 6; k++) cycle(1'b1, (k % 2) == 0, 1'b0);
    repeat (15) cycle(1'b1, 1'b1, 1'b0);
    repeat (12) cycle(1'b1, 1'b0, 1'b0);

    // 3: simultaneous rise.
    for (int k = 0; k <= 10; k++) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (k == 7) at_edge_chk("t3_conflict_edge7", 1'b0, 1'b1);
      if (k == 8) at_edge_chk("t3_conflict_edge8", 1'b0, 1'b0);
    end
    repeat (12) cycle(1'b1, 1'b0, 1'b0);

    // 4: set then reset one cycle later.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (25) cycle(1'b1, 1'b1, 1'b1);
    #1 chk("t4_final_q", {7'd0, q_track}, 8'd0);
    repeat (12) cycle(1'b1, 1'b0, 1'b0);

    // 5: asynchronous reset in the second cycle of an s pulse.
    for (int k = 0; k <= 8; k++) cycle(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1 chk("t5_async_reset", {5'd0, s, busy, q_track}, 8'd0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b0, 1'b0);

    // 6: two-cycle reset glitch while idle.
    repeat (2) cycle(1'b1, 1'b0, 1'b1);
    repeat (14) cycle(1'b1, 1'b0, 1'b0);

    // Randomised holds, bounces and glitches.
    for (int seg = 0; seg < 60; seg++) begin
      int kind_sel, len;
      logic a, b;
      kind_sel = $urandom_range(0, 2);
      len = $urandom_range(1, 30);
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if (kind_sel == 0) begin
        repeat (len) cycle(1'b1, a, b);
      end else if (kind_sel == 1) begin
        repeat (len % 9 + 1) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        repeat (len % 3 + 1) cycle(1'b1, a, b);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
      end
    end
    repeat (5) cycle(1'b1, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    stop_mon = 1;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/sr_pulse_driver.md
Name: sr_pulse_driver

Overview:
Upstream conditioning stage for the day-6 SR latch. It takes two raw, bouncy push-button inputs (set and reset), synchronises and debounces each one, and converts each debounced rising edge into a clean fixed-length s or r pulse. Its outputs drive the latch's s and r inputs directly, and it guarantees they are never high together (the forbidden s=r=1 case). It also provides q_track, a registered copy of the state the latch is expected to hold.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its debounced level before the level flips (legal range ≥2)
PULSE_LEN, 4, cycles each s/r output pulse stays high (legal range ≥1)

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
set_raw  in  1  raw set button, asynchronous to clk, may bounce
rst_raw  in  1  raw reset button, asynchronous to clk, may bounce
s  out  1  set pulse to the latch
r  out  1  reset pulse to the latch
q_track  out  1  expected latch state: 1 after an s pulse, 0 after an r pulse
conflict  out  1  one-cycle flag: both debounced edges arrived in the same cycle
busy  out  1  high while a pulse or gap is in progress

Behaviour:
- Reset (rst_n=0, asynchronous) sets s=0, r=0, q_track=0, conflict=0, busy=0. Synchronisers, debounced levels and counters clear to 0; the pending flag clears; the FSM goes to IDLE. Asserting reset mid-pulse drops the pulse immediately.
- Per-channel synchroniser: 2-flop chain. The synchronised value is valid 2 edges after the raw input changes.
- Per-channel debounce:
  - cnt is $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - cnt clears on any cycle where the synchronised value equals the debounced level.
  - Otherwise cnt increments. When cnt reaches DEBOUNCE_CYCLES-1, the debounced level toggles and cnt clears.
  - A single-cycle glitch shorter than DEBOUNCE_CYCLES never toggles the level.
- Edge detect: a rising edge on a debounced level produces a one-cycle event (set_ev or rst_ev). Falling edges produce nothing.
- FSM states: IDLE, SET_P, RST_P, GAP. plen counts 0..PULSE_LEN-1.
  - IDLE with set_ev only: go to SET_P; s=1 on the next edge; q_track=1 on that same edge.
  - IDLE with rst_ev only: go to RST_P; r=1; q_track=0.
  - IDLE with set_ev and rst_ev together: stay in IDLE, no pulse, conflict=1 for one cycle, q_track unchanged.
  - SET_P / RST_P: hold the output high for exactly PULSE_LEN cycles, then go to GAP with the output low.
  - GAP: lasts exactly 1 cycle with s=r=0, then IDLE; or the pending pulse starts directly if pending is set.
- Pending (one-deep):
  - An event of the opposite kind arriving during SET_P/RST_P/GAP is stored and issued after GAP.
  - An event of the same kind as the active pulse is dropped.
  - A second pending request overwrites the first, so the latest wins.
  - Simultaneous set_ev and rst_ev while busy set conflict=1 and do not touch pending.
- Invariants:
  - s and r are never 1 in the same cycle.
  - At least 1 cycle of s=r=0 separates any two pulses.
  - busy=1 exactly when the state is not IDLE.
- Latency: with stable inputs, s (or r) rises DEBOUNCE_CYCLES+3 edges after the first edge that samples the raw input high.
- All outputs are registered; no combinational path from set_raw/rst_raw to any output.

Decomposition:
- Shared package sr_drv_pkg holds:
  - FSM state encodings as localparams: IDLE=2'd0, SET_P=2'd1, RST_P=2'd2, GAP=2'd3.
  - The counter-width function.
- One natural sub-module, debounce_channel: synchroniser, debounce counter, debounced level and rising-edge event. It is instantiated twice, once for set and once for rst.
- The top level holds the FSM, pulse counter, pending flag and q_track.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_LEN=3):
1. Reset, then set_raw held high from cycle 0 → s=1 exactly at edges 7,8,9, then 0; q_track=1 from edge 7; r stays 0 throughout.
2. set_raw bounces 1,0,1,0 each cycle for 6 cycles, then stays high → no s pulse during the bounce; exactly one 3-cycle s pulse, starting 7 edges after the input settles.
3. set_raw and rst_raw rise on the same cycle → conflict=1 for exactly 1 cycle at edge 7; s=r=0; q_track unchanged.
4. set_raw rises, then rst_raw rises 1 cycle later → s high 3 cycles, 1 gap cycle with s=r=0, then r high 3 cycles; final q_track=0; s&r never 1 at any edge.
5. rst_n asserted asynchronously during the 2nd cycle of an s pulse → s=0, busy=0, q_track=0 immediately; no pulse after rst_n releases while both raw inputs are low.
6. A 2-cycle rst_raw glitch while idle → no r pulse and no conflict.
